// File: rtl/rom_word_streamer.sv
// Walks the image ROM in 2*WORDS-byte bursts and serialises each burst as a valid/ready stream.
// Define ROM_PREFETCH_EN to double-buffer the bursts so the stream has no bubble between them.
module rom_word_streamer #(
  parameter int IMG_BYTES  = 307200,
  parameter int ADDR_W     = 19,
  parameter int WORDS      = 10,
  parameter int START_ADDR = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [16*WORDS-1:0] rom_data,
  output logic [15:0]         out_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int                IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_BYTES - 2*WORDS);
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(2*WORDS);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(WORDS - 1);

  if (IMG_BYTES % (2*WORDS) != 0) begin : g_bad_img_size
    $error("IMG_BYTES must be a multiple of 2*WORDS");
  end

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             hs, last_burst;
  logic [15:0]      cur_word;

`ifdef ROM_PREFETCH_EN
  logic [15:0] burst_p0 [2][WORDS];
  logic        sel, cap_pend, cur_last, wr_sel;

  // rom_addr runs one burst ahead, so the last-burst flag is tracked separately
  assign last_burst = cur_last;
  assign cur_word   = burst_p0[sel][idx];
  assign wr_sel     = (state == FETCH) ? sel : ~sel;
`else
  logic [15:0] burst_p0 [WORDS];

  assign last_burst = (rom_addr >= LAST_ADDR);
  assign cur_word   = burst_p0[idx];
`endif

  assign hs       = out_valid & out_ready;
  assign out_last = out_valid & (idx == IDX_LAST) & last_burst;
  assign out_word = out_valid ? cur_word : 16'h0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = FETCH;
      FETCH: begin
        busy      = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (hs && idx == IDX_LAST) begin
`ifdef ROM_PREFETCH_EN
          state_nxt = last_burst ? DONE : STREAM;
`else
          state_nxt = last_burst ? DONE : FETCH;
`endif
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ROM addressing and word index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= FIRST_ADDR;
      idx      <= '0;
`ifdef ROM_PREFETCH_EN
      sel      <= 1'b0;
      cap_pend <= 1'b0;
      cur_last <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) rom_addr <= FIRST_ADDR;
        FETCH: begin
          idx <= '0;
`ifdef ROM_PREFETCH_EN
          cur_last <= (rom_addr >= LAST_ADDR);
          if (rom_addr < LAST_ADDR) begin
            rom_addr <= rom_addr + STEP;
            cap_pend <= 1'b1;
          end
`endif
        end
        STREAM: begin
`ifdef ROM_PREFETCH_EN
          cap_pend <= 1'b0;
`endif
          if (hs) begin
            if (idx == IDX_LAST) begin
              idx <= '0;
`ifdef ROM_PREFETCH_EN
              if (!cur_last) begin
                sel      <= ~sel;
                cur_last <= (rom_addr >= LAST_ADDR);
                if (rom_addr < LAST_ADDR) begin
                  rom_addr <= rom_addr + STEP;
                  cap_pend <= 1'b1;
                end
              end
`else
              if (rom_addr < LAST_ADDR) rom_addr <= rom_addr + STEP;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Burst capture from the ROM
  always_ff @(posedge clk) begin
`ifdef ROM_PREFETCH_EN
    if (state == FETCH || (state == STREAM && cap_pend)) begin
      for (int i = 0; i < WORDS; i++) burst_p0[wr_sel][i] <= rom_data[16*i +: 16];
    end
`else
    if (state == FETCH) begin
      for (int i = 0; i < WORDS; i++) burst_p0[i] <= rom_data[16*i +: 16];
    end
`endif
  end

endmodule
